// File: rtl/buck_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : buck_pwm_ctrl
// Description : Closed-loop buck PWM controller with integral duty update,
//               dead-time insertion and low-side diode emulation.
// Revision    : 1.0  initial release
// ============================================================================
module buck_pwm_ctrl #(
    parameter int WIDTH         = 18,
    parameter int PERIOD_CYCLES = 200,
    parameter int DEAD_CYCLES   = 4,
    parameter int DUTY_INIT     = 100,
    parameter int DUTY_MIN      = 0,
    parameter int DUTY_MAX      = 180,
    parameter int V_REF         = 2500,
    parameter int KI_SHIFT      = 6,
    parameter int STEP_MAX      = 8,
    parameter int I_THRESH      = 10
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic signed [WIDTH-1:0]                v_out,
    input  logic signed [WIDTH-1:0]                i_ind,
    output logic                                   hs,
    output logic                                   ls,
    output logic [$clog2(PERIOD_CYCLES+1)-1:0]     duty,
    output logic                                   period_start
);

    localparam int c_dw  = $clog2(PERIOD_CYCLES + 1);
    localparam int c_sw  = c_dw + 2;
    localparam int c_dcw = $clog2(DEAD_CYCLES + 1);

    localparam logic [1:0] c_s_off   = 2'd0;
    localparam logic [1:0] c_s_dead  = 2'd1;
    localparam logic [1:0] c_s_hs_on = 2'd2;
    localparam logic [1:0] c_s_ls_on = 2'd3;

    localparam logic [c_dw-1:0]         c_cnt_last   = c_dw'(PERIOD_CYCLES - 1);
    localparam logic [c_dw-1:0]         c_duty_init  = c_dw'(DUTY_INIT);
    localparam logic [c_dw-1:0]         c_duty_min   = c_dw'(DUTY_MIN);
    localparam logic [c_dw-1:0]         c_duty_max   = c_dw'(DUTY_MAX);
    localparam logic signed [c_sw-1:0]  c_sum_min    = c_sw'(DUTY_MIN);
    localparam logic signed [c_sw-1:0]  c_sum_max    = c_sw'(DUTY_MAX);
    localparam logic signed [WIDTH:0]   c_v_ref      = (WIDTH+1)'(V_REF);
    localparam logic signed [WIDTH:0]   c_step_pos   = (WIDTH+1)'(STEP_MAX);
    localparam logic signed [WIDTH:0]   c_step_neg   = (WIDTH+1)'(-STEP_MAX);
    localparam logic signed [c_sw-1:0]  c_step_pos_s = c_sw'(STEP_MAX);
    localparam logic signed [c_sw-1:0]  c_step_neg_s = c_sw'(-STEP_MAX);
    localparam logic signed [WIDTH-1:0] c_i_thresh   = WIDTH'(I_THRESH);
    localparam logic [c_dcw-1:0]        c_dead_init  = c_dcw'(DEAD_CYCLES - 1);

    logic [c_dw-1:0]         r_cnt;
    logic [c_dw-1:0]         r_duty;
    logic [1:0]              r_state;
    logic [c_dcw-1:0]        r_dead_cnt;
    logic                    r_period_start;

    logic signed [WIDTH:0]   w_err;
    logic signed [WIDTH:0]   w_shift;
    logic signed [c_sw-1:0]  w_step;
    logic signed [c_sw-1:0]  w_sum;
    logic [c_dw-1:0]         w_duty_nxt;
    logic                    w_hs_req;
    logic                    w_ls_ok;
    logic [1:0]              w_state_nxt;
    logic [c_dcw-1:0]        w_dead_nxt;

    // One extra bit keeps the error exact for any pair of WIDTH-bit operands
    assign w_err   = c_v_ref - $signed({v_out[WIDTH-1], v_out});
    assign w_shift = w_err >>> KI_SHIFT;
    assign w_sum   = $signed({2'b00, r_duty}) + w_step;

    always_comb begin
        w_step     = '0;
        w_duty_nxt = r_duty;
        if (w_shift > c_step_pos) begin
            w_step = c_step_pos_s;
        end else if (w_shift < c_step_neg) begin
            w_step = c_step_neg_s;
        end else begin
            w_step = w_shift[c_sw-1:0];
        end
        if (w_sum < c_sum_min) begin
            w_duty_nxt = c_duty_min;
        end else if (w_sum > c_sum_max) begin
            w_duty_nxt = c_duty_max;
        end else begin
            w_duty_nxt = w_sum[c_dw-1:0];
        end
    end

    assign w_hs_req = (r_cnt < r_duty);
    assign w_ls_ok  = (i_ind > c_i_thresh);

    // Duty register doubles as the shadow: it only loads at the period end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_duty         <= c_duty_init;
            r_period_start <= 1'b0;
        end else if (!en) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= (r_cnt == '0);
            if (r_cnt == c_cnt_last) begin
                r_cnt  <= '0;
                r_duty <= w_duty_nxt;
            end else begin
                r_cnt <= r_cnt + c_dw'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_s_off;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dead_cnt <= w_dead_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dead_nxt  = r_dead_cnt;
        if (!en) begin
            w_state_nxt = c_s_off;
            w_dead_nxt  = '0;
        end else begin
            case (r_state)
                c_s_off: begin
                    if (w_hs_req || w_ls_ok) begin
                        w_state_nxt = c_s_dead;
                        w_dead_nxt  = c_dead_init;
                    end
                end
                c_s_hs_on: begin
                    if (!w_hs_req) begin
                        w_state_nxt = c_s_dead;
                        w_dead_nxt  = c_dead_init;
                    end
                end
                c_s_ls_on: begin
                    if (w_hs_req || !w_ls_ok) begin
                        w_state_nxt = c_s_dead;
                        w_dead_nxt  = c_dead_init;
                    end
                end
                c_s_dead: begin
                    if (r_dead_cnt != '0) begin
                        w_dead_nxt = r_dead_cnt - c_dcw'(1);
                    end else if (w_hs_req) begin
                        w_state_nxt = c_s_hs_on;
                    end else if (w_ls_ok) begin
                        w_state_nxt = c_s_ls_on;
                    end else begin
                        w_state_nxt = c_s_off;
                    end
                end
                default: begin
                    w_state_nxt = c_s_off;
                    w_dead_nxt  = '0;
                end
            endcase
        end
    end

    assign hs           = (r_state == c_s_hs_on);
    assign ls           = (r_state == c_s_ls_on);
    assign duty         = r_duty;
    assign period_start = r_period_start;

endmodule
`default_nettype wire

// File: tb/tb_buck_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_buck_pwm_ctrl
// Description : Self-checking bench for buck_pwm_ctrl against a behavioural
//               switch/dead-time and integral-duty model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_buck_pwm_ctrl;

    localparam int WIDTH     = 18;
    localparam int P         = 200;
    localparam int DEAD      = 4;
    localparam int DUTY_INIT = 100;
    localparam int DUTY_MIN  = 0;
    localparam int DUTY_MAX  = 180;
    localparam int V_REF     = 2500;
    localparam int KI_SHIFT  = 6;
    localparam int STEP_MAX  = 8;
    localparam int I_THRESH  = 10;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    en;
    logic signed [WIDTH-1:0] v_out;
    logic signed [WIDTH-1:0] i_ind;
    logic                    hs;
    logic                    ls;
    logic [7:0]              duty;
    logic                    period_start;

    buck_pwm_ctrl #(
        .WIDTH(WIDTH), .PERIOD_CYCLES(P), .DEAD_CYCLES(DEAD),
        .DUTY_INIT(DUTY_INIT), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
        .V_REF(V_REF), .KI_SHIFT(KI_SHIFT), .STEP_MAX(STEP_MAX), .I_THRESH(I_THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .v_out(v_out), .i_ind(i_ind),
        .hs(hs), .ls(ls), .duty(duty), .period_start(period_start)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: which switch conducts (0 none, 1 high, 2 low) and remaining blanking cycles
    int         m_cnt, m_duty, m_on, m_gap;
    logic       e_hs, e_ls, e_ps;
    logic [7:0] e_duty;

    task automatic cycle();
        int nc, nd, non, ngap, want, err, stp;
        logic nps;
        if (!rst_n) begin
            nc = 0; nd = DUTY_INIT; non = 0; ngap = 0; nps = 1'b0;
        end else if (!en) begin
            nc = 0; nd = m_duty; non = 0; ngap = 0; nps = 1'b0;
        end else begin
            want = (m_cnt < m_duty) ? 1 : ((int'(i_ind) > I_THRESH) ? 2 : 0);
            nps  = (m_cnt == 0);
            nc   = (m_cnt == P - 1) ? 0 : m_cnt + 1;
            nd   = m_duty;
            if (m_cnt == P - 1) begin
                err = V_REF - int'(v_out);
                stp = err >>> KI_SHIFT;
                if (stp > STEP_MAX)  stp = STEP_MAX;
                if (stp < -STEP_MAX) stp = -STEP_MAX;
                nd = m_duty + stp;
                if (nd < DUTY_MIN) nd = DUTY_MIN;
                if (nd > DUTY_MAX) nd = DUTY_MAX;
            end
            non  = m_on;
            ngap = m_gap;
            if (m_gap > 0) begin
                ngap = m_gap - 1;
                if (ngap == 0) non = want;
            end else if (want != m_on) begin
                ngap = DEAD;
            end
        end
        @(posedge clk);
        m_cnt = nc; m_duty = nd; m_on = non; m_gap = ngap;
        e_hs   = (m_gap == 0) && (m_on == 1);
        e_ls   = (m_gap == 0) && (m_on == 2);
        e_ps   = nps;
        e_duty = 8'(m_duty);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; v_out = 18'(V_REF); i_ind = 18'(50);
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {1'b0, 1'b0, 1'b0, 8'(DUTY_INIT)}) begin
                $display("FAIL reset_state: got hs=%b ls=%b ps=%b duty=%0d want 0 0 0 %0d", hs, ls, period_start, duty, DUTY_INIT);
            end else n_pass++;
        end
        rst_n = 1'b1;
        cycle();
        n_total++;
        if ({hs, ls, period_start} !== 3'b001) begin
            $display("FAIL reset_first_ps: got hs=%b ls=%b ps=%b want 0 0 1", hs, ls, period_start);
        end else n_pass++;
    endtask

    task automatic test_regulated();
        int n, hs_cnt;
        n = P + ((1 - m_cnt + P) % P);
        for (int i = 0; i < n; i++) begin
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {e_hs, e_ls, e_ps, e_duty}) begin
                $display("FAIL reg_model: got %b%b%b/%0d want %b%b%b/%0d", hs, ls, period_start, duty, e_hs, e_ls, e_ps, e_duty);
            end else n_pass++;
        end
        for (int p = 0; p < 5; p++) begin
            hs_cnt = 0;
            for (int c = 0; c < P; c++) begin
                cycle();
                hs_cnt += int'(hs);
                n_total++;
                if (hs !== (m_cnt >= DEAD + 1 && m_cnt <= DUTY_INIT) ||
                    ls !== (m_cnt >= DUTY_INIT + DEAD + 1 || m_cnt == 0) || duty !== 8'(DUTY_INIT)) begin
                    $display("FAIL reg_timing cnt=%0d: got hs=%b ls=%b duty=%0d", m_cnt, hs, ls, duty);
                end else n_pass++;
            end
            n_total++;
            if (hs_cnt != DUTY_INIT - DEAD) begin
                $display("FAIL reg_hs_width: got %0d want %0d", hs_cnt, DUTY_INIT - DEAD);
            end else n_pass++;
        end
    endtask

    task automatic test_ls_drop();
        int n;
        n = (150 - m_cnt + P) % P;
        if (n == 0) n = P;
        for (int i = 0; i < n; i++) begin
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {e_hs, e_ls, e_ps, e_duty}) begin
                $display("FAIL lsdrop_model: got %b%b%b/%0d want %b%b%b/%0d", hs, ls, period_start, duty, e_hs, e_ls, e_ps, e_duty);
            end else n_pass++;
        end
        n_total++;
        if (ls !== 1'b1) begin
            $display("FAIL lsdrop_before: got ls=%b want 1", ls);
        end else n_pass++;
        i_ind = 18'(0);
        for (int i = 0; i < P - 1 - 150; i++) begin
            cycle();
            n_total++;
            if (hs !== 1'b0 || ls !== 1'b0 || {period_start, duty} !== {e_ps, e_duty}) begin
                $display("FAIL lsdrop_after cnt=%0d: got hs=%b ls=%b want 0 0", m_cnt, hs, ls);
            end else n_pass++;
        end
        i_ind = 18'(50);
    endtask

    task automatic test_en_drop();
        int n, waited;
        n = (50 - m_cnt + P) % P;
        if (n == 0) n = P;
        for (int i = 0; i < n; i++) begin
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {e_hs, e_ls, e_ps, e_duty}) begin
                $display("FAIL endrop_model: got %b%b%b/%0d want %b%b%b/%0d", hs, ls, period_start, duty, e_hs, e_ls, e_ps, e_duty);
            end else n_pass++;
        end
        n_total++;
        if (hs !== 1'b1) begin
            $display("FAIL endrop_hs_before: got hs=%b want 1", hs);
        end else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {1'b0, 1'b0, 1'b0, 8'(DUTY_INIT)}) begin
                $display("FAIL endrop_off: got hs=%b ls=%b ps=%b duty=%0d want 0 0 0 %0d", hs, ls, period_start, duty, DUTY_INIT);
            end else n_pass++;
        end
        en = 1'b1;
        waited = 0;
        do begin
            cycle();
            waited++;
            n_total++;
            if ({hs, ls, period_start, duty} !== {e_hs, e_ls, e_ps, e_duty}) begin
                $display("FAIL enback_model: got %b%b%b/%0d want %b%b%b/%0d", hs, ls, period_start, duty, e_hs, e_ls, e_ps, e_duty);
            end else n_pass++;
        end while (hs !== 1'b1 && waited < 20);
        n_total++;
        if (waited != DEAD + 1) begin
            $display("FAIL enback_latency: got %0d cycles want %0d", waited, DEAD + 1);
        end else n_pass++;
    endtask

    task automatic test_duty_ramp();
        int k, exp_d;
        k = 0;
        v_out = 18'(0);
        for (int i = 0; i < 12 * P; i++) begin
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {e_hs, e_ls, e_ps, e_duty}) begin
                $display("FAIL ramp_model: got %b%b%b/%0d want %b%b%b/%0d", hs, ls, period_start, duty, e_hs, e_ls, e_ps, e_duty);
            end else n_pass++;
            if (m_cnt == 0) begin
                k++;
                exp_d = (DUTY_INIT + STEP_MAX * k > DUTY_MAX) ? DUTY_MAX : DUTY_INIT + STEP_MAX * k;
                n_total++;
                if (duty !== 8'(exp_d)) begin
                    $display("FAIL ramp_step%0d: got duty=%0d want %0d", k, duty, exp_d);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_no_ls();
        int n;
        i_ind = 18'(5);
        v_out = 18'(V_REF);
        n = P + ((1 - m_cnt + P) % P);
        for (int i = 0; i < n; i++) begin
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {e_hs, e_ls, e_ps, e_duty}) begin
                $display("FAIL nols_model: got %b%b%b/%0d want %b%b%b/%0d", hs, ls, period_start, duty, e_hs, e_ls, e_ps, e_duty);
            end else n_pass++;
        end
        for (int i = 0; i < 2 * P; i++) begin
            cycle();
            n_total++;
            if (ls !== 1'b0 || hs !== (m_cnt >= DEAD + 1 && m_cnt <= DUTY_MAX)) begin
                $display("FAIL nols_timing cnt=%0d: got hs=%b ls=%b", m_cnt, hs, ls);
            end else n_pass++;
        end
        i_ind = 18'(50);
    endtask

    task automatic test_low_duty();
        v_out = 18'sh1FFFF;
        for (int i = 0; i < 25 * P; i++) begin
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {e_hs, e_ls, e_ps, e_duty}) begin
                $display("FAIL low_model: got %b%b%b/%0d want %b%b%b/%0d", hs, ls, period_start, duty, e_hs, e_ls, e_ps, e_duty);
            end else n_pass++;
            if (m_duty <= DEAD) begin
                n_total++;
                if (hs !== 1'b0 || (m_cnt == DEAD + 1 && ls !== 1'b1)) begin
                    $display("FAIL low_no_hs duty=%0d cnt=%0d: got hs=%b ls=%b", m_duty, m_cnt, hs, ls);
                end else n_pass++;
            end
        end
        n_total++;
        if (duty !== 8'(DUTY_MIN)) begin
            $display("FAIL low_clamp: got duty=%0d want %0d", duty, DUTY_MIN);
        end else n_pass++;
    endtask

    task automatic test_vmin();
        int k;
        k = 0;
        v_out = 18'sh20000;
        for (int i = 0; i < 3 * P; i++) begin
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {e_hs, e_ls, e_ps, e_duty}) begin
                $display("FAIL vmin_model: got %b%b%b/%0d want %b%b%b/%0d", hs, ls, period_start, duty, e_hs, e_ls, e_ps, e_duty);
            end else n_pass++;
            if (m_cnt == 0) begin
                k++;
                n_total++;
                if (duty !== 8'(DUTY_MIN + STEP_MAX * k)) begin
                    $display("FAIL vmin_step%0d: got duty=%0d want %0d", k, duty, DUTY_MIN + STEP_MAX * k);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        int off_left, t;
        off_left = 0;
        for (int i = 0; i < 20 * P; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                v_out = ($urandom_range(0, 1) == 0) ? 18'sh20000 : 18'sh1FFFF;
            end else begin
                t = int'($urandom_range(0, 4000));
                v_out = 18'(V_REF - 2000 + t);
            end
            if ($urandom_range(0, 7) == 0) begin
                t = int'($urandom_range(0, 60));
                i_ind = 18'(t - 20);
            end
            if (off_left > 0) begin
                off_left--;
                if (off_left == 0) en = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                en = 1'b0;
                off_left = int'($urandom_range(1, 30));
            end
            rst_n = !(i == 2000 || i == 2001);
            cycle();
            n_total++;
            if ({hs, ls, period_start, duty} !== {e_hs, e_ls, e_ps, e_duty} || (hs && ls)) begin
                $display("FAIL rand_model i=%0d: got %b%b%b/%0d want %b%b%b/%0d", i, hs, ls, period_start, duty, e_hs, e_ls, e_ps, e_duty);
            end else n_pass++;
        end
        rst_n = 1'b1;
        en = 1'b1;
    endtask

    initial begin
        m_cnt = 0; m_duty = DUTY_INIT; m_on = 0; m_gap = 0;
        test_reset();
        test_regulated();
        test_ls_drop();
        test_en_drop();
        test_duty_ramp();
        test_no_ls();
        test_low_duty();
        test_vmin();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/buck_pwm_ctrl.md
Name: buck_pwm_ctrl

Overview:
- Closed-loop digital PWM controller that generates the `hs`/`ls` gate signals consumed by the buck power-stage model.
- Samples the fixed-point output voltage `v_out` once per PWM period and updates the duty cycle with a saturated integral law.
- Inserts dead time on every switch transition.
- Applies diode emulation: `ls` is only allowed while `i_ind` is above a threshold.
- Sits between the emulated plant outputs (`v_out`, `i_ind`) and the plant switch inputs (`hs`, `ls`) in the emulation top level.

Parameters:
WIDTH, 18, bit width of signed fixed-point `v_out`, `i_ind`, `V_REF`, `I_THRESH` (same scaling as plant outputs)
PERIOD_CYCLES, 200, clock cycles per PWM period (500 kHz at 100 MHz clk)
DEAD_CYCLES, 4, dead-time length in clock cycles, >=1
DUTY_INIT, 100, duty (cycles) loaded at reset
DUTY_MIN, 0, lower duty clamp
DUTY_MAX, 180, upper duty clamp, must be < PERIOD_CYCLES-DEAD_CYCLES
V_REF, 2500, signed voltage setpoint in `v_out` units
KI_SHIFT, 6, integral gain as arithmetic right shift of error
STEP_MAX, 8, max abs duty change per period (cycles)
I_THRESH, 10, signed `i_ind` threshold for low-side enable

Ports:
clk  input  1  emulator clock
rst_n  input  1  synchronous active-low reset
en  input  1  controller enable; low forces both switches off
v_out  input  WIDTH  signed measured output voltage
i_ind  input  WIDTH  signed inductor current
hs  output  1  high-side switch command (registered)
ls  output  1  low-side switch command (registered)
duty  output  clog2(PERIOD_CYCLES+1)  active duty for current period
period_start  output  1  one-cycle pulse when cnt wraps to 0

Behaviour:
- Reset (`rst_n`=0 at clk edge): cnt=0, duty_reg=DUTY_INIT, duty=DUTY_INIT, state=OFF, dead_cnt=0, hs=0, ls=0, period_start=0. Reset mid-operation takes effect at the next edge regardless of state.
- Counter: cnt runs 0..PERIOD_CYCLES-1 and wraps. `period_start` is registered high for the cycle with cnt==0.
- `en`=0: cnt held at 0, duty_reg held, state forced to OFF, hs=ls=0 next cycle, `period_start`=0.
- Duty update at the edge where cnt==PERIOD_CYCLES-1:
  - err=V_REF-v_out, computed at WIDTH+1 bits signed.
  - step=err>>>KI_SHIFT, saturated to [-STEP_MAX,+STEP_MAX].
  - duty_reg=clamp(duty_reg+step, DUTY_MIN, DUTY_MAX).
  - `duty` shadow is loaded with the new value on the same edge, so it applies from cnt=0 of the next period. `duty` never changes mid-period.
- Combinational requests:
  - hs_req=(cnt<duty).
  - ls_ok=(i_ind>I_THRESH), signed compare.
- FSM states: OFF, DEAD, HS_ON, LS_ON. Transitions are evaluated each edge while en=1:
  - OFF: hs_req or ls_ok -> DEAD (dead_cnt=DEAD_CYCLES-1).
  - HS_ON: !hs_req -> DEAD.
  - LS_ON: hs_req or !ls_ok -> DEAD.
  - DEAD: dead_cnt!=0 -> decrement. When dead_cnt==0: hs_req -> HS_ON; else ls_ok -> LS_ON; else -> OFF.
- Outputs are decoded from the state register: hs=(state==HS_ON), ls=(state==LS_ON). `hs` and `ls` are never both 1.
- Every on-transition passes through DEAD for exactly DEAD_CYCLES cycles with both outputs low.
- Timing: with duty=D>DEAD_CYCLES and ls previously on, hs is high for cnt in [DEAD_CYCLES+1, D] (D-DEAD_CYCLES cycles). ls drops the cycle after cnt==0.
- Boundary cases:
  - duty=0: hs never asserts.
  - D<=DEAD_CYCLES: hs never asserts; DEAD resolves to LS_ON or OFF.
  - ls_ok falling while in LS_ON: ls low the next cycle.
  - hs_req rising during DEAD: DEAD completes its full count, then goes to HS_ON.
  - Both hs_req and !ls_ok true in LS_ON: single transition to DEAD.
  - v_out extremes (min/max signed): err is computed at WIDTH+1 bits, so no overflow; step saturates.

Test Plan:
- Reset with rst_n=0 for 5 cycles, en=1 -> hs=ls=0, duty=100, cnt=0. First period_start occurs 1 cycle after release.
- v_out=V_REF=2500, i_ind=50, en=1 for 5 periods -> duty stays 100. Per period: hs high for 96 cycles (cnt 5..100); ls high cnt 105..199 plus cnt 0; 4-cycle both-low gaps around each edge.
- v_out=0 constant -> err=2500, step=39 saturates to 8. Duty goes 108, 116, ... and holds at 180 (clamp) from period 11 on.
- i_ind=5 (<=I_THRESH), v_out=V_REF -> ls never asserts. After hs falls: DEAD for 4 cycles, then OFF.
- i_ind stepped from 50 to 0 at cnt=150 while ls=1 -> ls=0 at the next edge. State goes DEAD -> OFF; no glitch on hs.
- en dropped to 0 at cnt=50 while hs=1 -> hs=0 the next cycle and cnt holds 0. Re-asserting en restarts the period at cnt=0 with the held duty, and hs is first seen after the 4-cycle dead time.
